// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the multicycle LEGv8 main control unit.
// Holds the state encoding, opcode match constants, ALUop and ALUSrcB codes,
// and the one-hot opcode class bundle passed from the classifier to the FSM.
package legv8_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_RWB     = 4'd7,
        S_BR_CBZ  = 4'd8,
        S_BR_B    = 4'd9,
        S_HALT    = 4'd10
    } state_t;

    // Exact-match opcodes
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // Opcodes whose low bits belong to the immediate/offset field
    localparam logic [10:0] OP_ORRI      = 11'b10110010000;
    localparam logic [10:0] OP_ORRI_MASK = 11'b11111111110;
    localparam logic [10:0] OP_CBZ       = 11'b10110100000;
    localparam logic [10:0] OP_CBZ_MASK  = 11'b11111111000;
    localparam logic [10:0] OP_B         = 11'b00010100000;
    localparam logic [10:0] OP_B_MASK    = 11'b11111100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Exactly one member is set for any opcode value.
    typedef struct packed {
        logic mem_ld;
        logic mem_st;
        logic rtype;
        logic rimm;
        logic cbz;
        logic b;
        logic illegal;
    } opclass_t;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] val,
                                      input logic [10:0] mask);
        return (op & mask) == val;
    endfunction

endpackage

// File: rtl/multicycle_opclass.sv
// Opcode classifier: instruction[31:21] -> one-hot instruction class.
// Latency: purely combinational, no state.
// Backpressure: none; output follows the opcode input directly.
// Ports: opcode (11b in), opclass (opclass_t out, one-hot).
module multicycle_opclass
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output opclass_t    opclass
);

    logic known;

    always_comb begin
        opclass.mem_ld = (opcode == OP_LDUR);
        opclass.mem_st = (opcode == OP_STUR);
        opclass.rtype  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                         (opcode == OP_AND) || (opcode == OP_ORR);
        opclass.rimm   = op_match(opcode, OP_ORRI, OP_ORRI_MASK);
        opclass.cbz    = op_match(opcode, OP_CBZ,  OP_CBZ_MASK);
        opclass.b      = op_match(opcode, OP_B,    OP_B_MASK);
        known          = opclass.mem_ld | opclass.mem_st | opclass.rtype |
                         opclass.rimm | opclass.cbz | opclass.b;
        opclass.illegal = ~known;
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle LEGv8 datapath (fetch/decode/exec/mem/wb).
// Latency: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3 cycles with zero-wait memory.
// Backpressure: FETCH/MEMRD/MEMWR hold their strobes and state until MemReady=1.
// Ports: CLK, Reset (async, active-high), Opcode[10:0], MemReady in; ALUop[1:0],
//   ALUSrcA, ALUSrcB[1:0], IorD, datapath strobes, State[3:0], Illegal out.
// Build option: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN traps unknown opcodes in HALT;
//   without it an unknown opcode retires as a NOP and Illegal is tied low.
module multicycle_control
    import legv8_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic [10:0] Opcode,
    input  logic        MemReady,
    output logic [1:0]  ALUop,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        Reg2Loc,
    output logic        PCSource,
    output logic [3:0]  State,
    output logic        Illegal
);

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = S_HALT;
`else
    localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

    state_t   state;
    state_t   next_state;
    opclass_t cls;

    multicycle_opclass u_opclass (
        .opcode  (Opcode),
        .opclass (cls)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        ALUop       = ALUOP_ADD;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        PCSource    = 1'b0;

        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                // The IR and PC+4 may only be committed once memory delivers,
                // and never while reset is holding the FSM in FETCH.
                IRWrite = MemReady & ~Reset;
                PCWrite = MemReady & ~Reset;
                if (MemReady) next_state = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ALUSrcB    = SRCB_IMM_SH;
                next_state = S_FETCH;
                if (cls.mem_ld || cls.mem_st)   next_state = S_MEMADDR;
                else if (cls.rtype || cls.rimm) next_state = S_EXEC_R;
                else if (cls.cbz)               next_state = S_BR_CBZ;
                else if (cls.b)                 next_state = S_BR_B;
                else if (cls.illegal)           next_state = ILLEGAL_NEXT;
            end
            S_MEMADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = cls.mem_ld ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (MemReady) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) next_state = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = cls.rimm ? SRCB_IMM : SRCB_REG;
                ALUop      = ALUOP_RTYPE;
                next_state = S_RWB;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_BR_CBZ: begin
                ALUSrcA     = 1'b1;
                ALUop       = ALUOP_CBZ;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                next_state  = S_FETCH;
            end
            S_BR_B: begin
                PCWrite    = 1'b1;
                PCSource   = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Register 2 read address comes from Rt for stores and CBZ once the IR
    // is valid, i.e. in every state after FETCH.
    assign Reg2Loc = (state != S_FETCH) && (cls.mem_st || cls.cbz);
    assign State   = state;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    assign Illegal = (state == S_HALT);
`else
    assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [10:0] Opcode;
    logic        MemReady;
    logic [1:0]  ALUop;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        IorD, IRWrite, PCWrite, PCWriteCond, MemRead, MemWrite;
    logic        MemtoReg, RegWrite, Reg2Loc, PCSource, Illegal;
    logic [3:0]  State;

    int n_cmp = 0;
    int n_err = 0;

    // Expected-vector layout: [19:16] State, [15:14] ALUop, [13] ALUSrcA,
    // [12:11] ALUSrcB, [10] IorD, [9:1] IRWrite,PCWrite,PCWriteCond,MemRead,
    // MemWrite,MemtoReg,RegWrite,Reg2Loc,PCSource, [0] Illegal.
    typedef struct {
        logic [10:0] op;
        logic        rdy;
        logic [19:0] exp;
    } ent_t;

    ent_t sb_q[$];

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] CBZ  = 11'b10110100101;
    localparam logic [10:0] ORRI = 11'b10110010001;
    localparam logic [10:0] BR   = 11'b00010100011;
    localparam logic [10:0] BAD  = 11'b11111111111;

    multicycle_control dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .Reg2Loc(Reg2Loc), .PCSource(PCSource),
        .State(State), .Illegal(Illegal)
    );

    always #5 CLK = ~CLK;

    function automatic logic [19:0] observe();
        return {State, ALUop, ALUSrcA, ALUSrcB, IorD, IRWrite, PCWrite,
                PCWriteCond, MemRead, MemWrite, MemtoReg, RegWrite, Reg2Loc,
                PCSource, Illegal};
    endfunction

    task automatic push(input logic [10:0] op, input logic rdy,
                        input logic [3:0] st, input logic [1:0] alu,
                        input logic sa, input logic [1:0] sb, input logic iord,
                        input logic [8:0] stb, input logic ill);
        ent_t e;
        e.op  = op;
        e.rdy = rdy;
        e.exp = {st, alu, sa, sb, iord, stb, ill};
        sb_q.push_back(e);
    endtask

    // FETCH: MemRead, PC+4 on the ALU, IR/PC writes only when memory is ready.
    task automatic push_fetch(input logic [10:0] op, input logic rdy);
        push(op, rdy, 4'd0, 2'b00, 1'b0, 2'b01, 1'b0,
             rdy ? 9'b110100000 : 9'b000100000, 1'b0);
    endtask

    task automatic push_decode(input logic [10:0] op, input logic r2l);
        push(op, 1'b1, 4'd1, 2'b00, 1'b0, 2'b11, 1'b0, {7'b0, r2l, 1'b0}, 1'b0);
    endtask

    task automatic push_add(input logic [10:0] op);
        push_fetch(op, 1'b1);
        push_decode(op, 1'b0);
        push(op, 1'b1, 4'd6, 2'b10, 1'b1, 2'b00, 1'b0, 9'b000000000, 1'b0);
        push(op, 1'b1, 4'd7, 2'b00, 1'b0, 2'b00, 1'b0, 9'b000000100, 1'b0);
    endtask

    task automatic test_reset();
        ent_t e;
        logic [19:0] obs;
        // Reset held: FETCH outputs with IRWrite/PCWrite suppressed even though
        // memory reports ready.
        push(ADD, 1'b1, 4'd0, 2'b00, 1'b0, 2'b01, 1'b0, 9'b000100000, 1'b0);
        push(ADD, 1'b1, 4'd0, 2'b00, 1'b0, 2'b01, 1'b0, 9'b000100000, 1'b0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            Opcode = e.op; MemReady = e.rdy;
            @(negedge CLK);
            obs = observe();
            n_cmp++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL reset: got %h want %h", obs, e.exp);
            end
            @(posedge CLK); #1;
        end
        Reset = 1'b0;
    endtask

    task automatic test_rtype_add();
        ent_t e;
        logic [19:0] obs;
        push_add(ADD);
        push_fetch(ADD, 1'b0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            Opcode = e.op; MemReady = e.rdy;
            @(negedge CLK);
            obs = observe();
            n_cmp++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL add st%0d: got %h want %h", e.exp[19:16], obs, e.exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_load_stall();
        ent_t e;
        logic [19:0] obs;
        push_fetch(LDUR, 1'b1);
        push_decode(LDUR, 1'b0);
        push(LDUR, 1'b1, 4'd2, 2'b00, 1'b1, 2'b10, 1'b0, 9'b000000000, 1'b0);
        push(LDUR, 1'b0, 4'd3, 2'b00, 1'b0, 2'b00, 1'b1, 9'b000100000, 1'b0);
        push(LDUR, 1'b0, 4'd3, 2'b00, 1'b0, 2'b00, 1'b1, 9'b000100000, 1'b0);
        push(LDUR, 1'b1, 4'd3, 2'b00, 1'b0, 2'b00, 1'b1, 9'b000100000, 1'b0);
        push(LDUR, 1'b1, 4'd4, 2'b00, 1'b0, 2'b00, 1'b0, 9'b000001100, 1'b0);
        push_fetch(LDUR, 1'b0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            Opcode = e.op; MemReady = e.rdy;
            @(negedge CLK);
            obs = observe();
            n_cmp++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL ldur st%0d: got %h want %h", e.exp[19:16], obs, e.exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_store();
        ent_t e;
        logic [19:0] obs;
        push_fetch(STUR, 1'b1);
        push_decode(STUR, 1'b1);
        push(STUR, 1'b1, 4'd2, 2'b00, 1'b1, 2'b10, 1'b0, 9'b000000010, 1'b0);
        push(STUR, 1'b0, 4'd5, 2'b00, 1'b0, 2'b00, 1'b1, 9'b000010010, 1'b0);
        push(STUR, 1'b1, 4'd5, 2'b00, 1'b0, 2'b00, 1'b1, 9'b000010010, 1'b0);
        push_fetch(STUR, 1'b0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            Opcode = e.op; MemReady = e.rdy;
            @(negedge CLK);
            obs = observe();
            n_cmp++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL stur st%0d: got %h want %h", e.exp[19:16], obs, e.exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_cbz();
        ent_t e;
        logic [19:0] obs;
        push_fetch(CBZ, 1'b1);
        push_decode(CBZ, 1'b1);
        push(CBZ, 1'b1, 4'd8, 2'b01, 1'b1, 2'b00, 1'b0, 9'b001000011, 1'b0);
        push_fetch(CBZ, 1'b0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            Opcode = e.op; MemReady = e.rdy;
            @(negedge CLK);
            obs = observe();
            n_cmp++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL cbz st%0d: got %h want %h", e.exp[19:16], obs, e.exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    // B with a one-cycle fetch stall, then ORRI and ADD issued without gaps.
    task automatic test_back_to_back();
        ent_t e;
        logic [19:0] obs;
        push_fetch(BR, 1'b0);
        push_fetch(BR, 1'b1);
        push_decode(BR, 1'b0);
        push(BR, 1'b0, 4'd9, 2'b00, 1'b0, 2'b00, 1'b0, 9'b010000001, 1'b0);
        push_fetch(ORRI, 1'b1);
        push_decode(ORRI, 1'b0);
        push(ORRI, 1'b1, 4'd6, 2'b10, 1'b1, 2'b10, 1'b0, 9'b000000000, 1'b0);
        push(ORRI, 1'b1, 4'd7, 2'b00, 1'b0, 2'b00, 1'b0, 9'b000000100, 1'b0);
        push_add(ADD);
        push_fetch(ADD, 1'b0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            Opcode = e.op; MemReady = e.rdy;
            @(negedge CLK);
            obs = observe();
            n_cmp++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL b2b st%0d: got %h want %h", e.exp[19:16], obs, e.exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_illegal();
        ent_t e;
        logic [19:0] obs;
        push_fetch(BAD, 1'b1);
        push_decode(BAD, 1'b0);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++)
            push(BAD, 1'($urandom_range(0, 1)), 4'd10, 2'b00, 1'b0, 2'b00, 1'b0,
                 9'b000000000, 1'b1);
`else
        push_fetch(BAD, 1'b0);
        push_fetch(BAD, 1'b0);
`endif
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            Opcode = e.op; MemReady = e.rdy;
            @(negedge CLK);
            obs = observe();
            n_cmp++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL illegal st%0d: got %h want %h", e.exp[19:16], obs, e.exp);
            end
            @(posedge CLK); #1;
        end
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        ent_t e;
        logic [19:0] obs;
        logic [19:0] want;
        push_fetch(LDUR, 1'b1);
        push_decode(LDUR, 1'b0);
        push(LDUR, 1'b1, 4'd2, 2'b00, 1'b1, 2'b10, 1'b0, 9'b000000000, 1'b0);
        push(LDUR, 1'b0, 4'd3, 2'b00, 1'b0, 2'b00, 1'b1, 9'b000100000, 1'b0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            Opcode = e.op; MemReady = e.rdy;
            @(negedge CLK);
            obs = observe();
            n_cmp++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL rst_pre st%0d: got %h want %h", e.exp[19:16], obs, e.exp);
            end
            @(posedge CLK); #1;
        end
        // Still stalled in MEMRD; assert reset between clock edges.
        MemReady = 1'b0;
        @(negedge CLK); #1;
        Reset = 1'b1;
        MemReady = 1'b1;
        #1;
        want = {4'd0, 2'b00, 1'b0, 2'b01, 1'b0, 9'b000100000, 1'b0};
        obs = observe();
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL async_reset: got %h want %h", obs, want);
        end
        @(posedge CLK); #1;
        Reset = 1'b0;
        push_add(ADD);
        push_fetch(ADD, 1'b0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            Opcode = e.op; MemReady = e.rdy;
            @(negedge CLK);
            obs = observe();
            n_cmp++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL rst_resume st%0d: got %h want %h", e.exp[19:16], obs, e.exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        Reset    = 1'b1;
        MemReady = 1'b0;
        Opcode   = 11'd0;
        #2;
        test_reset();
        test_rtype_add();
        test_load_stall();
        test_store();
        test_cbz();
        test_back_to_back();
        test_illegal();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
